mmio_slot_bridge: RTL and testbench

Upstream master for the MMIO slot interface: accepts single CPU load/store requests on a valid/ready channel, decodes the target slot, and drives the shared slot bus (chip_select, read, write, addr, wr_data, transaction_completed) into GPIO, timer and other slots. It collects rd_data, rd_done/wr_done and error flags from the selected slot and returns one response per request. A timeout guards against slots that never complete.

---
 rtl/mmio_pkg.sv | 24 ++
 rtl/mmio_slot_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_slot_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO slot bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RESP_OK      = 2'b00,
        RESP_SLVERR  = 2'b01,
        RESP_DECERR  = 2'b10,
        RESP_TIMEOUT = 2'b11
    } resp_err_e;

    localparam int SLOT_OFFSET_W = 8;
    localparam int SLOT_IDX_LSB  = 8;
    localparam int SLOT_IDX_W    = 4;

endpackage

// File: rtl/mmio_slot_bridge.sv
// Bridges single CPU load/store requests onto the shared MMIO slot bus, one response per request.
// Latency: slot_cs 1 cycle after accept; decode error responds 1 cycle after accept; otherwise slot-paced.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, no new request meanwhile.
module mmio_slot_bridge
    import mmio_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    req_write,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic [1:0]              resp_err,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    slot_read,
    output logic                    slot_write,
    output logic [7:0]              slot_addr,
    output logic [31:0]             slot_wr_data,
    output logic                    slot_transaction_completed,
    input  logic [32*NUM_SLOTS-1:0] slot_rd_data,
    input  logic [NUM_SLOTS-1:0]    slot_rd_done,
    input  logic [NUM_SLOTS-1:0]    slot_wr_done,
    input  logic [NUM_SLOTS-1:0]    slot_slave_error,
    input  logic [NUM_SLOTS-1:0]    slot_decode_error
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    // Timer value seen on the last permitted cycle of a phase.
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   T_MAX  = TW'(TIMEOUT_CYCLES);

    state_e                      state_q, state_d;
    resp_err_e                   err_q, err_d;
    logic [SLOT_IDX_W-1:0]       idx_q, idx_d;
    logic                        write_q, write_d;
    logic [SLOT_OFFSET_W-1:0]    addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [NUM_SLOTS-1:0]        cs_q, cs_d;
    logic                        rd_q, rd_d;
    logic                        wr_q, wr_d;
    logic                        tc_q, tc_d;
    logic                        rvld_q, rvld_d;

    logic [SLOT_IDX_W-1:0]       req_idx;
    logic [31:0]                 sel_rdata;
    logic                        sel_rd_done, sel_wr_done, sel_slverr, sel_decerr;
    logic                        sel_done, timer_last;
    logic                        unused_addr_bits;

    assign req_idx          = req_addr[SLOT_IDX_LSB +: SLOT_IDX_W];
    assign unused_addr_bits = ^req_addr[31:SLOT_IDX_LSB+SLOT_IDX_W];
    assign sel_done         = sel_rd_done | sel_wr_done;
    assign timer_last       = (timer_q >= T_LAST);

    // Mux the selected slot's data and status flags by the latched index.
    always_comb begin
        sel_rdata   = '0;
        sel_rd_done = 1'b0;
        sel_wr_done = 1'b0;
        sel_slverr  = 1'b0;
        sel_decerr  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == SLOT_IDX_W'(i)) begin
                sel_rdata   = slot_rd_data[32*i +: 32];
                sel_rd_done = slot_rd_done[i];
                sel_wr_done = slot_wr_done[i];
                sel_slverr  = slot_slave_error[i];
                sel_decerr  = slot_decode_error[i];
            end
        end
    end

    // Next-state and next-output logic; every slot/response output is a flop.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        idx_d   = idx_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        timer_d = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);
        cs_d    = cs_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        tc_d    = tc_q;
        rvld_d  = rvld_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_idx;
                    write_d = req_write;
                    addr_d  = req_addr[SLOT_OFFSET_W-1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = RESP_OK;
                    timer_d = '0;
                    if (int'(req_idx) >= NUM_SLOTS) begin
                        // Unmapped slot: answer directly, bus stays quiet.
                        err_d   = RESP_DECERR;
                        rvld_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            cs_d[i] = (req_idx == SLOT_IDX_W'(i));
                        end
                        rd_d    = !req_write;
                        wr_d    = req_write;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_done || timer_last) begin
                    cs_d    = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    tc_d    = 1'b1;
                    timer_d = '0;
                    state_d = ST_COMPLETE;
                    if (!sel_done) begin
                        err_d   = RESP_TIMEOUT;
                        rdata_d = '0;
                    end else begin
                        err_d   = sel_decerr ? RESP_DECERR :
                                  sel_slverr ? RESP_SLVERR : RESP_OK;
                        // Read data is only meaningful for a clean read.
                        rdata_d = (!write_q && !sel_decerr && !sel_slverr) ? sel_rdata : '0;
                    end
                end
            end
            ST_COMPLETE: begin
                if ((!sel_rd_done && !sel_wr_done) || timer_last) begin
                    tc_d    = 1'b0;
                    rvld_d  = 1'b1;
                    state_d = ST_RESP;
                    // Slot never released its done: keep an earlier error, else flag timeout.
                    if ((sel_rd_done || sel_wr_done) && err_q == RESP_OK) begin
                        err_d   = RESP_TIMEOUT;
                        rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rvld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            err_q   <= RESP_OK;
            idx_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            timer_q <= '0;
            cs_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            tc_q    <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            tc_q    <= tc_d;
            rvld_q  <= rvld_d;
        end
    end

    assign req_ready                  = (state_q == ST_IDLE);
    assign resp_valid                 = rvld_q;
    assign resp_rdata                 = rdata_q;
    assign resp_err                   = err_q;
    assign slot_cs                    = cs_q;
    assign slot_read                  = rd_q;
    assign slot_write                 = wr_q;
    assign slot_addr                  = addr_q;
    assign slot_wr_data               = wdata_q;
    assign slot_transaction_completed = tc_q;

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// Directed self-checking bench for mmio_slot_bridge with four modelled slots.
// Latency: slot models answer one cycle after seeing a command and hold done until deselected.
// Backpressure: response stalls are driven explicitly from the stimulus sequence.
module tb_mmio_slot_bridge;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         resp_valid, resp_ready;
    logic [31:0]  resp_rdata;
    logic [1:0]   resp_err;
    logic [3:0]   slot_cs;
    logic         slot_read, slot_write, slot_transaction_completed;
    logic [7:0]   slot_addr;
    logic [31:0]  slot_wr_data;
    logic [127:0] slot_rd_data;
    logic [3:0]   slot_rd_done, slot_wr_done, slot_slave_error, slot_decode_error;

    logic [31:0]  cfg_rdata [4];
    logic [3:0]   cfg_silent, cfg_stuck, cfg_slverr, cfg_decerr;
    logic [3:0]   m_rd, m_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_slot_bridge #(.NUM_SLOTS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
        .slot_addr(slot_addr), .slot_wr_data(slot_wr_data),
        .slot_transaction_completed(slot_transaction_completed),
        .slot_rd_data(slot_rd_data), .slot_rd_done(slot_rd_done),
        .slot_wr_done(slot_wr_done), .slot_slave_error(slot_slave_error),
        .slot_decode_error(slot_decode_error)
    );

    // Slot models: done follows a registered view of chip select and command.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_rd <= '0;
            m_wr <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_rd[i] <= !cfg_silent[i] && slot_cs[i] && slot_read;
                m_wr[i] <= !cfg_silent[i] && slot_cs[i] && slot_write;
            end
        end
    end

    always_comb begin
        slot_rd_data = '0;
        for (int i = 0; i < 4; i++) slot_rd_data[32*i +: 32] = cfg_rdata[i];
    end
    assign slot_rd_done      = m_rd | cfg_stuck;
    assign slot_wr_done      = m_wr;
    assign slot_slave_error  = cfg_slverr;
    assign slot_decode_error = cfg_decerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request; returns just after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count cycles (from the one after accept) until resp_valid, and transaction_completed cycles.
    task automatic wait_resp(input string tag, input int exp_cyc, input int exp_tc);
        int cyc = 0;
        int tc  = 0;
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            if (slot_transaction_completed) tc++;
            if (resp_valid) seen = 1;
        end
        chk({tag, "_seen"}, 32'(resp_valid), 32'd1);
        chk({tag, "_lat"}, cyc, exp_cyc);
        chk({tag, "_tc"}, tc, exp_tc);
    endtask

    task automatic take_resp(input string tag, input logic [1:0] err, input logic [31:0] rd);
        chk({tag, "_err"}, 32'(resp_err), 32'(err));
        chk({tag, "_rdata"}, resp_rdata, rd);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_vld_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n     = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        cfg_silent = '0;
        cfg_stuck  = '0;
        cfg_slverr = '0;
        cfg_decerr = '0;
        cfg_rdata[0] = 32'h0000_0000;
        cfg_rdata[1] = 32'hDEAD_BEEF;
        cfg_rdata[2] = 32'h0000_1234;
        cfg_rdata[3] = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cs", 32'(slot_cs), 32'd0);
        chk("rst_rd_wr", 32'({slot_read, slot_write}), 32'd0);
        chk("rst_tc", 32'(slot_transaction_completed), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_addr", 32'(slot_addr), 32'd0);
        chk("rst_wdata", slot_wr_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Write 0xF to slot 0 offset 0
        issue(32'h0000_0000, 1'b1, 32'h0000_000F);
        chk("wr0_cs", 32'(slot_cs), 32'h1);
        chk("wr0_write", 32'(slot_write), 32'd1);
        chk("wr0_read", 32'(slot_read), 32'd0);
        chk("wr0_wdata", slot_wr_data, 32'h0000_000F);
        chk("wr0_busy", 32'(req_ready), 32'd0);
        wait_resp("wr0", 5, 2);
        take_resp("wr0", 2'b00, 32'd0);

        // Read slot 1 offset 0x04
        issue(32'h0000_0104, 1'b0, 32'd0);
        chk("rd1_cs", 32'(slot_cs), 32'h2);
        chk("rd1_read", 32'(slot_read), 32'd1);
        chk("rd1_addr", 32'(slot_addr), 32'h04);
        wait_resp("rd1", 5, 2);
        take_resp("rd1", 2'b00, 32'hDEAD_BEEF);

        // Unmapped slot index 5 and 15
        issue(32'h0000_0500, 1'b0, 32'd0);
        chk("dec5_cs", 32'(slot_cs), 32'd0);
        wait_resp("dec5", 1, 0);
        take_resp("dec5", 2'b10, 32'd0);
        issue(32'h0000_0F0C, 1'b1, 32'h1111_2222);
        chk("dec15_wr", 32'(slot_write), 32'd0);
        wait_resp("dec15", 1, 0);
        take_resp("dec15", 2'b10, 32'd0);

        // Slot-reported decode error wins over slave error; slave error alone
        cfg_decerr[2] = 1'b1;
        cfg_slverr[2] = 1'b1;
        issue(32'h0000_020C, 1'b0, 32'd0);
        chk("sdec_addr", 32'(slot_addr), 32'h0C);
        wait_resp("sdec", 5, 2);
        take_resp("sdec", 2'b10, 32'd0);
        cfg_slverr[3] = 1'b1;
        issue(32'h0000_0310, 1'b1, 32'hCAFE_F00D);
        wait_resp("slv", 5, 2);
        take_resp("slv", 2'b01, 32'd0);
        cfg_decerr = '0;
        cfg_slverr = '0;

        // Silent slot: 8 ACCESS cycles, then one COMPLETE cycle
        cfg_silent[0] = 1'b1;
        issue(32'h0000_0008, 1'b0, 32'd0);
        wait_resp("silent", 10, 1);
        take_resp("silent", 2'b11, 32'd0);
        cfg_silent[0] = 1'b0;

        // Done stuck high: immediate done, then 8 COMPLETE cycles before timeout
        cfg_stuck[1] = 1'b1;
        issue(32'h0000_0120, 1'b0, 32'd0);
        wait_resp("stuck", 10, 8);
        take_resp("stuck", 2'b11, 32'd0);
        cfg_stuck[1] = 1'b0;

        // Backpressure: response held stable, new request ignored
        issue(32'h0000_01FC, 1'b0, 32'd0);
        wait_resp("bp", 5, 2);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0000;
        req_write = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
            chk("bp_cs", 32'(slot_cs), 32'd0);
        end
        req_valid = 1'b0;
        take_resp("bp", 2'b00, 32'hDEAD_BEEF);

        // Reset in the middle of ACCESS
        cfg_silent[0] = 1'b1;
        issue(32'h0000_0010, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre_cs", 32'(slot_cs), 32'h1);
        #1 arst_n = 1'b0;
        #1;
        chk("arst_cs", 32'(slot_cs), 32'd0);
        chk("arst_read", 32'(slot_read), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        cfg_silent[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("arst_no_resp", 32'(resp_valid), 32'd0);
        end

        // Recovery after reset
        issue(32'h0000_0044, 1'b1, 32'h0000_00A5);
        chk("post_addr", 32'(slot_addr), 32'h44);
        wait_resp("post", 5, 2);
        take_resp("post", 2'b00, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
